// File: rtl/pb_fb_dram_arb.sv
// rtl/pb_fb_dram_arb.sv - two-port burst arbiter in front of the burst SDRAM controller
//
// Shares one burst SDRAM controller between the display scan-out fetcher (port 0, reads
// only) and the CPU cache refill/writeback port (port 1, reads and writes). One burst is
// in flight at a time. The arbiter owns the controller command interface, routes read
// beats and write-ready to the granted port, counts beats and pulses completion.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   p0_req_i, p0_urgent_i          display burst-read request (level) / FIFO low-water
//   p0_addr_i                      display burst address
//   p0_gnt_o, p0_rvld_o, p0_done_o grant pulse, read beat valid, burst-done pulse
//   p1_req_i, p1_we_i              CPU burst request (level) / direction, 1 = write
//   p1_addr_i, p1_din_i            CPU burst address / write data
//   p1_gnt_o, p1_rvld_o            grant pulse, read beat valid
//   p1_wrdy_o, p1_done_o           write beat accepted, burst-done pulse
//   dout_o, din_o                  shared read data / controller write data (pass-through)
//   cmd_bst_rd_req_o, cmd_bst_we_req_o, cmd_addr_o   controller command
//   cmd_bst_rd_ack_i, cmd_bst_we_ack_i               controller burst acknowledge
//   r_vld_i, w_rdy_i, ctrl_dout_i                    controller data handshake
module pb_fb_dram_arb #(
  parameter int AW        = 23,
  parameter int DW        = 16,
  parameter int BURST_LEN = 32,
  parameter int CNT_BW    = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          p0_req_i,
  input  logic          p0_urgent_i,
  input  logic [AW-1:0] p0_addr_i,
  output logic          p0_gnt_o,
  output logic          p0_rvld_o,
  output logic          p0_done_o,
  input  logic          p1_req_i,
  input  logic          p1_we_i,
  input  logic [AW-1:0] p1_addr_i,
  input  logic [DW-1:0] p1_din_i,
  output logic          p1_gnt_o,
  output logic          p1_rvld_o,
  output logic          p1_wrdy_o,
  output logic          p1_done_o,
  output logic [DW-1:0] dout_o,
  output logic          cmd_bst_rd_req_o,
  output logic          cmd_bst_we_req_o,
  output logic [AW-1:0] cmd_addr_o,
  output logic [DW-1:0] din_o,
  input  logic          cmd_bst_rd_ack_i,
  input  logic          cmd_bst_we_ack_i,
  input  logic          r_vld_i,
  input  logic          w_rdy_i,
  input  logic [DW-1:0] ctrl_dout_i
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY} state_e;

  state_e            state_q, state_d;
  logic              sel_q, sel_d;     // granted port
  logic              wr_q, wr_d;       // direction of the burst in flight
  logic              last_q, last_d;   // port served last, loses the next tie
  logic [CNT_BW-1:0] cnt_q, cnt_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic              done0_q, done0_d, done1_q, done1_d;
  logic              rd_req_q, rd_req_d, we_req_q, we_req_d;

  logic ack, beat, pick0, pick1;

  // Only the acknowledge matching the issued direction counts.
  assign ack  = wr_q ? cmd_bst_we_ack_i : cmd_bst_rd_ack_i;
  // Beats past the burst length are masked so a chatty controller cannot overrun a port.
  assign beat = (state_q == S_BUSY) & (wr_q ? w_rdy_i : r_vld_i) & ack
              & (cnt_q < CNT_BW'(BURST_LEN));

  // Port 0 wins when urgent, when alone, or when port 1 was served last.
  assign pick0 = p0_req_i & (p0_urgent_i | ~p1_req_i | last_q);
  assign pick1 = p1_req_i & ~pick0;

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    wr_d     = wr_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    rd_req_d = rd_req_q;
    we_req_d = we_req_q;
    gnt0_d   = 1'b0;
    gnt1_d   = 1'b0;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick0 | pick1) begin
          sel_d    = pick1;
          wr_d     = pick1 & p1_we_i;
          addr_d   = pick1 ? p1_addr_i : p0_addr_i;
          gnt0_d   = pick0;
          gnt1_d   = pick1;
          rd_req_d = ~(pick1 & p1_we_i);
          we_req_d = pick1 & p1_we_i;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (ack) begin
          rd_req_d = 1'b0;
          we_req_d = 1'b0;
          cnt_d    = '0;
          state_d  = S_BUSY;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q + CNT_BW'(beat);
        // The controller holds ack for the whole burst; its fall ends the burst even if short.
        if (!ack) begin
          done0_d = ~sel_q;
          done1_d = sel_q;
          last_d  = sel_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      sel_q    <= 1'b0;
      wr_q     <= 1'b0;
      last_q   <= 1'b1;
      cnt_q    <= '0;
      addr_q   <= '0;
      rd_req_q <= 1'b0;
      we_req_q <= 1'b0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      wr_q     <= wr_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      rd_req_q <= rd_req_d;
      we_req_q <= we_req_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
    end
  end

  assign p0_gnt_o         = gnt0_q;
  assign p1_gnt_o         = gnt1_q;
  assign p0_done_o        = done0_q;
  assign p1_done_o        = done1_q;
  assign cmd_bst_rd_req_o = rd_req_q;
  assign cmd_bst_we_req_o = we_req_q;
  assign cmd_addr_o       = addr_q;

  // Beat strobes are decoded from registered state and the live controller handshake so
  // they line up with the pass-through dout/din of the same cycle.
  assign p0_rvld_o = beat & ~sel_q & ~wr_q;
  assign p1_rvld_o = beat & sel_q & ~wr_q;
  assign p1_wrdy_o = beat & wr_q;

  assign dout_o = ctrl_dout_i;
  assign din_o  = p1_din_i;

endmodule

// File: tb/tb_pb_fb_dram_arb.sv
// tb/tb_pb_fb_dram_arb.sv - self-checking bench for pb_fb_dram_arb
module tb_pb_fb_dram_arb;
  localparam int AW = 23;
  localparam int DW = 16;
  localparam int BL = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Requesters: a port requests while it has asked for more bursts than it has completed.
  int ask0 = 0, ask1 = 0, got0 = 0, got1 = 0;
  wire p0_req = (ask0 != got0);
  wire p1_req = (ask1 != got1);
  logic          p0_urgent = 1'b0;
  logic          p1_we = 1'b0;
  logic [AW-1:0] p0_addr = '0, p1_addr = '0;
  logic [DW-1:0] p1_din = '0;

  // Controller stand-in; its outputs collapse with the shared reset.
  logic rd_ack_r = 1'b0, we_ack_r = 1'b0, r_vld_r = 1'b0, w_rdy_r = 1'b0;
  logic [DW-1:0] ctrl_dout = '0;
  wire rd_ack = rd_ack_r & rst_n;
  wire we_ack = we_ack_r & rst_n;
  wire r_vld  = r_vld_r & rst_n;
  wire w_rdy  = w_rdy_r & rst_n;
  int  ctl_beats = BL;

  logic p0_gnt, p0_rvld, p0_done, p1_gnt, p1_rvld, p1_wrdy, p1_done;
  logic cmd_rd, cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] dout, din;

  pb_fb_dram_arb #(.AW(AW), .DW(DW), .BURST_LEN(BL), .CNT_BW(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req_i(p0_req), .p0_urgent_i(p0_urgent), .p0_addr_i(p0_addr),
    .p0_gnt_o(p0_gnt), .p0_rvld_o(p0_rvld), .p0_done_o(p0_done),
    .p1_req_i(p1_req), .p1_we_i(p1_we), .p1_addr_i(p1_addr), .p1_din_i(p1_din),
    .p1_gnt_o(p1_gnt), .p1_rvld_o(p1_rvld), .p1_wrdy_o(p1_wrdy), .p1_done_o(p1_done),
    .dout_o(dout), .cmd_bst_rd_req_o(cmd_rd), .cmd_bst_we_req_o(cmd_we),
    .cmd_addr_o(cmd_addr), .din_o(din),
    .cmd_bst_rd_ack_i(rd_ack), .cmd_bst_we_ack_i(we_ack),
    .r_vld_i(r_vld), .w_rdy_i(w_rdy), .ctrl_dout_i(ctrl_dout)
  );

  int n_chk = 0, n_fail = 0;
  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Behavioural reference: phase 0 idle, 1 command issued, 2 data phase.
  int m_ph, m_sel, m_last, m_cnt, m_win;
  logic m_wr, m_ack, e_g0, e_g1, e_d0, e_d1;
  logic [AW-1:0] m_addr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph = 0; m_last = 1; m_sel = 0; m_wr = 1'b0; m_cnt = 0; m_addr = '0;
      e_g0 = 1'b0; e_g1 = 1'b0; e_d0 = 1'b0; e_d1 = 1'b0;
    end else begin
      e_g0 = 1'b0; e_g1 = 1'b0; e_d0 = 1'b0; e_d1 = 1'b0;
      m_ack = m_wr ? we_ack : rd_ack;
      if (m_ph == 0) begin
        m_win = -1;
        if (p0_req && p0_urgent) m_win = 0;
        else if (p0_req && p1_req) m_win = (m_last == 1) ? 0 : 1;
        else if (p0_req) m_win = 0;
        else if (p1_req) m_win = 1;
        if (m_win >= 0) begin
          m_sel = m_win;
          m_wr = (m_win == 1) && p1_we;
          m_addr = (m_win == 1) ? p1_addr : p0_addr;
          if (m_win == 0) e_g0 = 1'b1; else e_g1 = 1'b1;
          m_ph = 1;
        end
      end else if (m_ph == 1) begin
        if (m_ack) begin m_ph = 2; m_cnt = 0; end
      end else begin
        if ((m_wr ? w_rdy : r_vld) && m_ack && m_cnt < BL) m_cnt++;
        if (!m_ack) begin
          if (m_sel == 0) e_d0 = 1'b1; else e_d1 = 1'b1;
          m_last = m_sel;
          m_ph = 0;
        end
      end
    end
  end

  // Transaction bookkeeping kept by the compare process.
  int glog[$];
  logic [DW-1:0] cap[$];
  int nd0 = 0, nd1 = 0, cur0 = 0, cur1 = 0, last0 = -1, last1 = -1, out0 = 0, out1 = 0;
  logic e_beat;

  function automatic int glog_at(input int i);
    return (i < glog.size()) ? glog[i] : -1;
  endfunction

  always @(posedge clk) if (p1_wrdy) cap.push_back(din);
  always @(posedge clk) if (p1_wrdy) p1_din <= p1_din + 1'b1;

  initial begin
    forever begin
      @(negedge clk); #2;
      e_beat = (m_ph == 2) && (m_wr ? (w_rdy && we_ack) : (r_vld && rd_ack)) && (m_cnt < BL);
      chk("p0_gnt", p0_gnt, e_g0);
      chk("p1_gnt", p1_gnt, e_g1);
      chk("p0_done", p0_done, e_d0);
      chk("p1_done", p1_done, e_d1);
      chk("p0_rvld", p0_rvld, e_beat && !m_wr && m_sel == 0);
      chk("p1_rvld", p1_rvld, e_beat && !m_wr && m_sel == 1);
      chk("p1_wrdy", p1_wrdy, e_beat && m_wr);
      chk("rd_req", cmd_rd, m_ph == 1 && !m_wr);
      chk("we_req", cmd_we, m_ph == 1 && m_wr);
      chk("cmd_addr", cmd_addr, m_addr);
      chk("rd_we_excl", cmd_rd & cmd_we, 0);
      chk("dout_pass", dout, ctrl_dout);
      chk("din_pass", din, p1_din);
      if (!rst_n) begin
        got0 = ask0; got1 = ask1; cur0 = 0; cur1 = 0; out0 = 0; out1 = 0;
      end else begin
        if (p0_rvld) cur0++;
        if (p1_rvld || p1_wrdy) cur1++;
        if (p0_gnt) begin glog.push_back(0); out0++; chk("gnt0_pair", out0, 1); end
        if (p1_gnt) begin glog.push_back(1); out1++; chk("gnt1_pair", out1, 1); end
        if (p0_done) begin chk("done0_pair", out0, 1); out0--; nd0++; got0++; last0 = cur0; cur0 = 0; end
        if (p1_done) begin chk("done1_pair", out1, 1); out1--; nd1++; got1++; last1 = cur1; cur1 = 0; end
      end
    end
  end

  // Controller stand-in: ack one cycle after the request, then beats with one idle gap.
  logic c_wr;
  initial begin
    forever begin
      @(negedge clk); #1;
      if (rst_n && (cmd_rd || cmd_we)) begin
        c_wr = cmd_we;
        @(negedge clk); #1;
        if (c_wr) we_ack_r = 1'b1; else rd_ack_r = 1'b1;
        @(negedge clk); #1;
        for (int i = 0; i < ctl_beats + 1 && rst_n; i++) begin
          if (c_wr) w_rdy_r = (i != 5); else r_vld_r = (i != 5);
          ctrl_dout = DW'(16'hA000 + i);
          @(negedge clk); #1;
        end
        rd_ack_r = 1'b0; we_ack_r = 1'b0; r_vld_r = 1'b0; w_rdy_r = 1'b0;
      end
    end
  end

  task automatic wait_dones(input int target, input string nm);
    int n = 0;
    while ((nd0 + nd1) < target && n < 2000) begin @(negedge clk); n++; end
    #3;
    chk({"timeout_", nm}, ((nd0 + nd1) >= target), 1);
  endtask

  int base;
  initial begin
    repeat (3) @(negedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk); #3;
    chk("rst_cmd_addr", cmd_addr, 0);
    chk("rst_outs", {p0_gnt, p1_gnt, p0_done, p1_done, cmd_rd, cmd_we}, 0);

    // Single CPU write burst, data 0..31.
    ctl_beats = 32; p1_we = 1'b1; p1_addr = 23'h000123; ask1++;
    wait_dones(1, "t1");
    chk("t1_glog_n", glog.size(), 1);
    chk("t1_glog0", glog_at(0), 1);
    chk("t1_beats", last1, 32);
    chk("t1_ncap", cap.size(), 32);
    for (int i = 0; i < 32 && i < cap.size(); i++) chk("t1_data", cap[i], i);

    // Display read where the controller over-delivers 36 beats.
    ctl_beats = 36; p1_we = 1'b0; p0_addr = 23'h07ABCD; ask0++;
    wait_dones(2, "t2");
    chk("t2_beats", last0, 32);
    chk("t2_nd0", nd0, 1);
    chk("t2_glog1", glog_at(1), 0);

    // Reset in the middle of a display read.
    ctl_beats = 32; p0_addr = 23'h001000; ask0++;
    for (int n = 0; n < 500 && cur0 < 5; n++) @(negedge clk);
    #3;
    chk("t4_timeout", cur0 >= 5, 1);
    rst_n = 1'b0;
    @(negedge clk); #3;
    chk("t4_outs", {p0_gnt, p0_rvld, p0_done, p1_gnt, p1_rvld, p1_wrdy, p1_done, cmd_rd, cmd_we}, 0);
    chk("t4_addr", cmd_addr, 0);
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b1;
    chk("t4_no_done", nd0, 1);
    chk("t4_glog2", glog_at(2), 0);

    // Both ports requesting reads after reset: strict alternation, port 0 first.
    base = nd0 + nd1; p1_we = 1'b0; p0_addr = 23'h002000; p1_addr = 23'h003000;
    ask0 += 2; ask1 += 2;
    wait_dones(base + 4, "t3");
    chk("t3_g0", glog_at(3), 0);
    chk("t3_g1", glog_at(4), 1);
    chk("t3_g2", glog_at(5), 0);
    chk("t3_g3", glog_at(6), 1);
    chk("t3_beats", last1, 32);

    // Urgent display request raised during a CPU write burst, CPU keeps requesting.
    base = nd0 + nd1; p1_we = 1'b1; p1_addr = 23'h004000; ask1 += 2;
    for (int n = 0; n < 500 && cur1 < 3; n++) @(negedge clk);
    #3;
    chk("t5_timeout", cur1 >= 3, 1);
    p0_urgent = 1'b1; p0_addr = 23'h005000; ask0++;
    wait_dones(base + 3, "t5");
    p0_urgent = 1'b0;
    chk("t5_g0", glog_at(7), 1);
    chk("t5_g1", glog_at(8), 0);
    chk("t5_g2", glog_at(9), 1);
    chk("t5_beats", last1, 32);

    // Port 0 served last, both request with urgent set: port 0 wins again.
    base = nd0 + nd1; p1_we = 1'b0; ask0++;
    wait_dones(base + 1, "t6a");
    p0_urgent = 1'b1; ask0++; ask1++;
    wait_dones(base + 3, "t6b");
    p0_urgent = 1'b0;
    chk("t6_g0", glog_at(10), 0);
    chk("t6_g1", glog_at(11), 0);
    chk("t6_g2", glog_at(12), 1);

    repeat (3) @(negedge clk);
    #3;
    chk("end_out0", out0, 0);
    chk("end_out1", out1, 0);
    chk("end_ncap", cap.size(), 96);
    if (cap.size() == 96) chk("end_lastdata", cap[95], 95);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
